// File: rtl/axis_switch_sched.sv
// Packet-boundary scheduler for a 1:2 AXI-Stream switch: tracks packet framing on
// the input taps, moves port_select only between packets, and counts packets per port.
module axis_switch_sched #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cfg_mode,
  input  logic          cfg_manual_port,
  input  logic [15:0]   cfg_burst,
  input  logic          clear_counts,
  input  logic          mon_tvalid,
  input  logic          mon_tready,
  input  logic          mon_tlast,
  output logic          port_select,
  output logic          in_packet,
  output logic          switch_pending,
  output logic [CW-1:0] pkt_count0,
  output logic [CW-1:0] pkt_count1
);

  localparam int unsigned BW  = 16;
  localparam int unsigned BSW = BW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          r_port_select;
  logic [BW-1:0] r_burst_cnt;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;

  logic          w_beat;
  logic          w_eop;
  logic          w_boundary;
  logic          w_desired;
  logic          w_change;
  logic [BSW-1:0] w_burst_sum;
  logic [BSW-1:0] w_burst_lim;

  assign w_beat     = mon_tvalid & mon_tready;
  assign w_eop      = w_beat & mon_tlast;
  assign w_boundary = w_eop | ((r_state == S_IDLE) & ~w_beat);

  // Burst length of 0 behaves as 1; the sum includes a packet ending this cycle.
  assign w_burst_sum = {1'b0, r_burst_cnt} + BSW'(w_eop);
  assign w_burst_lim = (cfg_burst == 16'd0) ? BSW'(1) : {1'b0, cfg_burst};

  always_comb begin
    w_desired = r_port_select;
    if (!cfg_mode) begin
      w_desired = cfg_manual_port;
    end else if (w_burst_sum >= w_burst_lim) begin
      w_desired = ~r_port_select;
    end
  end

  assign w_change = w_boundary & (w_desired != r_port_select);

  // Packet framing FSM: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_beat && !mon_tlast) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_eop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_port_select <= 1'b0;
    end else if (w_boundary) begin
      r_port_select <= w_desired;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_burst_cnt <= '0;
    end else if (!cfg_mode || w_change) begin
      r_burst_cnt <= '0;
    end else if (w_eop && (r_burst_cnt != {BW{1'b1}})) begin
      r_burst_cnt <= r_burst_cnt + BW'(1);
    end
  end

  // Saturating per-port packet counters; clear wins over increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (clear_counts) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_eop) begin
      if (!r_port_select && (r_cnt0 != {CW{1'b1}})) r_cnt0 <= r_cnt0 + CW'(1);
      if (r_port_select && (r_cnt1 != {CW{1'b1}}))  r_cnt1 <= r_cnt1 + CW'(1);
    end
  end

  assign port_select    = r_port_select;
  assign in_packet      = (r_state == S_BUSY);
  assign switch_pending = (w_desired != r_port_select);
  assign pkt_count0     = r_cnt0;
  assign pkt_count1     = r_cnt1;

endmodule

// File: tb/tb_axis_switch_sched.sv
// Directed bench for axis_switch_sched with a 4-bit counter build so saturation is reachable.
module tb_axis_switch_sched;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          resetn;
  logic          cfg_mode;
  logic          cfg_manual_port;
  logic [15:0]   cfg_burst;
  logic          clear_counts;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          port_select;
  logic          in_packet;
  logic          switch_pending;
  logic [CW-1:0] pkt_count0;
  logic [CW-1:0] pkt_count1;

  int total;
  int bad;

  axis_switch_sched #(.CW(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cfg_mode        (cfg_mode),
    .cfg_manual_port (cfg_manual_port),
    .cfg_burst       (cfg_burst),
    .clear_counts    (clear_counts),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .port_select     (port_select),
    .in_packet       (in_packet),
    .switch_pending  (switch_pending),
    .pkt_count0      (pkt_count0),
    .pkt_count1      (pkt_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic drive_beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cfg_mode = 1'b0;
    cfg_manual_port = 1'b0;
    cfg_burst = 16'd1;
    clear_counts = 1'b0;
    set_idle();
    #12;
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b exp=0", port_select); end
    total++; if (in_packet !== 1'b0) begin bad++; $display("FAIL reset_inpkt got=%b exp=0", in_packet); end
    total++; if (switch_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", switch_pending); end
    total++; if (pkt_count0 !== 4'd0 || pkt_count1 !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pkt_count0, pkt_count1); end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_manual_idle();
    cfg_manual_port = 1'b1;
    #1;
    total++; if (switch_pending !== 1'b1) begin bad++; $display("FAIL midle_pending got=%b exp=1", switch_pending); end
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL midle_ps_before got=%b exp=0", port_select); end
    step();
    total++; if (port_select !== 1'b1) begin bad++; $display("FAIL midle_ps_after got=%b exp=1", port_select); end
    total++; if (switch_pending !== 1'b0) begin bad++; $display("FAIL midle_pending_after got=%b exp=0", switch_pending); end
    cfg_manual_port = 1'b0;
    step();
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL midle_ps_back got=%b exp=0", port_select); end
  endtask

  task automatic test_manual_busy();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    drive_beat(1'b0);
    total++; if (in_packet !== 1'b1) begin bad++; $display("FAIL mbusy_inpkt got=%b exp=1", in_packet); end
    cfg_manual_port = 1'b1;
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
    #1;
    total++; if (switch_pending !== 1'b1) begin bad++; $display("FAIL mbusy_pending got=%b exp=1", switch_pending); end
    step();
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL mbusy_ps_b2 got=%b exp=0", port_select); end
    drive_beat(1'b0);
    drive_beat(1'b0);
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL mbusy_ps_b4 got=%b exp=0", port_select); end
    mon_tlast = 1'b1;
    #1;
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL mbusy_ps_b5 got=%b exp=0", port_select); end
    step();
    set_idle();
    total++; if (port_select !== 1'b1) begin bad++; $display("FAIL mbusy_ps_eop got=%b exp=1", port_select); end
    total++; if (in_packet !== 1'b0) begin bad++; $display("FAIL mbusy_inpkt_end got=%b exp=0", in_packet); end
    total++; if (pkt_count0 !== 4'd1) begin bad++; $display("FAIL mbusy_cnt0 got=%0d exp=1", pkt_count0); end
  endtask

  task automatic test_rr_burst3();
    logic exp_ps;
    cfg_manual_port = 1'b0;
    step();
    cfg_mode = 1'b1;
    cfg_burst = 16'd3;
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL rr3_start_ps got=%b exp=0", port_select); end
    for (int k = 1; k <= 6; k++) begin
      exp_ps = (k <= 3) ? 1'b0 : 1'b1;
      total++; if (port_select !== exp_ps) begin bad++; $display("FAIL rr3_pkt%0d_ps got=%b exp=%b", k, port_select, exp_ps); end
      drive_beat(1'b0);
      total++; if (port_select !== exp_ps) begin bad++; $display("FAIL rr3_pkt%0d_mid_ps got=%b exp=%b", k, port_select, exp_ps); end
      drive_beat(1'b1);
    end
    set_idle();
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL rr3_end_ps got=%b exp=0", port_select); end
    total++; if (pkt_count0 !== 4'd3 || pkt_count1 !== 4'd3) begin bad++; $display("FAIL rr3_counts got=%0d/%0d exp=3/3", pkt_count0, pkt_count1); end
    step();
  endtask

  task automatic test_rr_burst0();
    logic exp_ps;
    cfg_burst = 16'd0;
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_ps = (i % 2 == 1) ? 1'b1 : 1'b0;
      total++; if (port_select !== exp_ps) begin bad++; $display("FAIL rr0_pkt%0d_ps got=%b exp=%b", i, port_select, exp_ps); end
      drive_beat(1'b1);
      total++; if (in_packet !== 1'b0) begin bad++; $display("FAIL rr0_pkt%0d_inpkt got=%b exp=0", i, in_packet); end
    end
    set_idle();
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL rr0_end_ps got=%b exp=0", port_select); end
    total++; if (pkt_count0 !== 4'd3 || pkt_count1 !== 4'd3) begin bad++; $display("FAIL rr0_counts got=%0d/%0d exp=3/3", pkt_count0, pkt_count1); end
    step();
  endtask

  task automatic test_saturate();
    cfg_mode = 1'b0;
    cfg_manual_port = 1'b0;
    cfg_burst = 16'd1;
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive_beat(1'b1);
      if (i == 15 || i == 16) begin
        total++; if (pkt_count0 !== 4'd15) begin bad++; $display("FAIL sat_pkt%0d got=%0d exp=15", i, pkt_count0); end
      end
    end
    clear_counts = 1'b1;
    drive_beat(1'b1);
    clear_counts = 1'b0;
    set_idle();
    total++; if (pkt_count0 !== 4'd0) begin bad++; $display("FAIL sat_clear got=%0d exp=0", pkt_count0); end
    step();
  endtask

  task automatic test_reset_mid();
    cfg_manual_port = 1'b1;
    step();
    total++; if (port_select !== 1'b1) begin bad++; $display("FAIL rmid_ps_pre got=%b exp=1", port_select); end
    drive_beat(1'b1);
    total++; if (pkt_count1 !== 4'd1) begin bad++; $display("FAIL rmid_cnt1_pre got=%0d exp=1", pkt_count1); end
    drive_beat(1'b0);
    drive_beat(1'b0);
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (port_select !== 1'b0) begin bad++; $display("FAIL rmid_ps got=%b exp=0", port_select); end
    total++; if (in_packet !== 1'b0) begin bad++; $display("FAIL rmid_inpkt got=%b exp=0", in_packet); end
    total++; if (pkt_count0 !== 4'd0 || pkt_count1 !== 4'd0) begin bad++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", pkt_count0, pkt_count1); end
    cfg_manual_port = 1'b0;
    set_idle();
    step();
    resetn = 1'b1;
    #1;
    total++; if (in_packet !== 1'b0) begin bad++; $display("FAIL rmid_post_inpkt got=%b exp=0", in_packet); end
    total++; if (switch_pending !== 1'b0) begin bad++; $display("FAIL rmid_post_pending got=%b exp=0", switch_pending); end
    step();
    drive_beat(1'b0);
    total++; if (in_packet !== 1'b1) begin bad++; $display("FAIL rmid_newpkt_inpkt got=%b exp=1", in_packet); end
    drive_beat(1'b1);
    set_idle();
    total++; if (pkt_count0 !== 4'd1) begin bad++; $display("FAIL rmid_newpkt_cnt0 got=%0d exp=1", pkt_count0); end
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_manual_idle();
    test_manual_busy();
    test_rr_burst3();
    test_rr_burst0();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_switch_sched.md
AXIS_SWITCH_SCHED -- requirements
Module: axis_switch_sched

Interface
REQ-001 SHALL have parameter CW, default 32, meaning width of each per-port packet counter.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port cfg_mode  input  1  0 = manual select, 1 = round-robin.
REQ-005 SHALL have port cfg_manual_port  input  1  requested output port in manual mode.
REQ-006 SHALL have port cfg_burst  input  16  packets per port before toggling in round-robin; 0 is treated as 1.
REQ-007 SHALL have port clear_counts  input  1  synchronous clear of both packet counters.
REQ-008 SHALL have port mon_tvalid  input  1  tap of the switch input TVALID.
REQ-009 SHALL have port mon_tready  input  1  tap of the switch input TREADY.
REQ-010 SHALL have port mon_tlast  input  1  tap of the switch input TLAST.
REQ-011 SHALL have port port_select  output  1  registered port select driving the switch.
REQ-012 SHALL have port in_packet  output  1  high while a packet is partly transferred.
REQ-013 SHALL have port switch_pending  output  1  high when the desired port differs from port_select.
REQ-014 SHALL have port pkt_count0  output  CW  completed packets routed to port 0.
REQ-015 SHALL have port pkt_count1  output  CW  completed packets routed to port 1.

Function
REQ-016 SHALL define beat = mon_tvalid & mon_tready and eop = beat & mon_tlast.
REQ-017 SHALL implement a two-state FSM: IDLE (between packets) and BUSY (mid-packet); in_packet = (state == BUSY).
REQ-018 SHALL transition IDLE->BUSY on beat & !mon_tlast, BUSY->IDLE on eop, and otherwise hold state; a single-beat packet (eop in IDLE) SHALL leave the FSM in IDLE.
REQ-019 SHALL define boundary = eop | (state == IDLE & !beat); port_select SHALL change only on a clock edge where boundary is true.
REQ-020 SHALL compute desired port: manual mode = cfg_manual_port; round-robin mode = !port_select when burst_cnt + eop >= max(cfg_burst,1), else port_select.
REQ-021 SHALL load port_select with the desired port at each boundary edge (one-cycle latency from a qualifying boundary to the new select).
REQ-022 SHALL keep a 16-bit burst_cnt that increments on eop in round-robin mode, clears on any edge where port_select changes, and is held at 0 in manual mode.
REQ-023 SHALL drive switch_pending combinationally as (desired port != port_select).
REQ-024 SHALL increment pkt_count0 on eop with port_select = 0 and pkt_count1 on eop with port_select = 1.
REQ-025 SHALL saturate each packet counter at 2^CW-1 with no wrap.
REQ-026 SHALL give clear_counts priority over an increment in the same cycle, resulting in 0.
REQ-027 SHALL defer any mode or cfg_manual_port change made while BUSY until the packet's eop edge.
REQ-028 SHALL never change port_select on an edge with beat & !mon_tlast.

Reset
REQ-029 SHALL, while resetn is low, asynchronously force state = IDLE, port_select = 0, burst_cnt = 0, pkt_count0 = 0 and pkt_count1 = 0.
REQ-030 SHALL, after reset deasserts mid-packet, treat the next beat as a new packet start.
REQ-031 SHALL, after reset deasserts, make in_packet = 0 and switch_pending a function of the current cfg inputs only.

Verification
REQ-032 Manual mode, idle bus, cfg_manual_port 0->1 -> port_select = 1 one cycle later, switch_pending high for exactly that one cycle.
REQ-033 Manual mode, cfg_manual_port toggled on the 2nd beat of a 5-beat packet -> port_select stays 0 through beat 5 and becomes 1 on the edge after the tlast beat; pkt_count0 = 1.
REQ-034 Round-robin, cfg_burst = 3, six 2-beat packets -> packets 1-3 go to port 0 and 4-6 to port 1; pkt_count0 = 3, pkt_count1 = 3.
REQ-035 Round-robin, cfg_burst = 0, back-to-back single-beat packets with tready held high -> port alternates every packet; the FSM never leaves IDLE.
REQ-036 CW = 4, 17 packets on port 0 with clear_counts asserted coincident with the 17th eop -> pkt_count0 saturates at 15, then reads 0 after the 17th eop.
REQ-037 resetn pulsed low during the 3rd beat of a packet on port 1 -> port_select = 0, counters = 0 and in_packet = 0 immediately, without waiting for a clock edge.
